uart_fifo_ctrl: RTL and testbench
=================================

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries per direction; power of two, 2..256.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tx_wr  input  1  host push strobe for the TX FIFO, one byte per cycle.
REQ-006 tx_data  input  8  byte pushed on tx_wr.
REQ-007 tx_full  output  1  TX FIFO holds DEPTH bytes.
REQ-008 tx_count  output  AW+1  TX FIFO occupancy.
REQ-009 rx_rd  input  1  host pop strobe for the RX FIFO.
REQ-010 rx_data  output  8  head of RX FIFO (show-ahead); valid when rx_empty=0.
REQ-011 rx_empty  output  1  RX FIFO holds 0 bytes.
REQ-012 rx_count  output  AW+1  RX FIFO occupancy.
REQ-013 rx_ovf  output  1  sticky flag: a received byte was dropped.
REQ-014 ovf_clr  input  1  clears rx_ovf.
REQ-015 cts  input  1  UART transmitter idle.
REQ-016 send  output  1  one-cycle pulse starting a UART transmit.
REQ-017 out_byte  output  8  byte presented to the UART transmitter.
REQ-018 data_rdy  input  1  UART receiver holds a new byte.
REQ-019 in_byte  input  8  byte from the UART receiver.
REQ-020 clear  output  1  one-cycle pulse acknowledging data_rdy.

Function
REQ-021 The TX FSM SHALL have states T_IDLE, T_LOAD, T_START, T_WAIT.
REQ-022 T_IDLE -> T_LOAD when tx_count>0 and cts=1; T_LOAD pops the TX head into out_byte.
REQ-023 T_LOAD -> T_START; in T_START send=1 for exactly one cycle with out_byte stable.
REQ-024 T_START -> T_WAIT; T_WAIT -> T_IDLE on first cycle cts=1, at least 2 cycles after send.
REQ-025 out_byte SHALL remain unchanged from T_LOAD until the next T_LOAD.
REQ-026 Back-to-back bytes SHALL be separated by at least 3 cycles after cts returns high.
REQ-027 The RX FSM SHALL have states R_IDLE, R_ACK, R_WAIT.
REQ-028 R_IDLE -> R_ACK when data_rdy=1: push in_byte if rx_count<DEPTH, else drop and set rx_ovf.
REQ-029 In R_ACK clear=1 for one cycle; R_ACK -> R_WAIT.
REQ-030 R_WAIT -> R_IDLE when data_rdy=0; each data_rdy assertion yields exactly one push.
REQ-031 tx_wr while tx_full SHALL be ignored; no pointer or count change.
REQ-032 rx_rd while rx_empty SHALL be ignored; rx_data undefined but no state change.
REQ-033 Simultaneous push and pop on one FIFO SHALL leave count unchanged and both complete.
REQ-034 A pop on a full FIFO with a simultaneous push SHALL succeed.
REQ-035 Pointers SHALL be AW bits, wrapping from DEPTH-1 to 0; count is AW+1 bits.
REQ-036 When ovf_clr and a drop coincide, rx_ovf SHALL end at 1 (set wins).
REQ-037 Flags and counts SHALL reflect the update on the cycle following the strobe.

Reset
REQ-038 On rst=0 both FSMs SHALL enter T_IDLE/R_IDLE immediately and asynchronously.
REQ-039 On rst=0, both FIFOs empty: counts 0, tx_full=0, rx_empty=1, rx_ovf=0.
REQ-040 On rst=0, send=0, clear=0, out_byte=8'h00; FIFO storage need not be cleared.
REQ-041 Reset during T_START or T_WAIT SHALL abort the byte; no send pulse after release.

Verification
REQ-042 Push 8'h41, 8'h42 with cts held high, then drop cts 1 cycle after each send and raise it after 20 cycles -> two send pulses, out_byte 41 then 42, tx_count 2->0.
REQ-043 Push 9 bytes with DEPTH=8 and cts=0 -> tx_full=1 after 8 pushes, 9th ignored, tx_count=8.
REQ-044 Assert data_rdy with in_byte=8'h5A, drop it 1 cycle after clear -> one clear pulse, rx_count=1, rx_data=5A.
REQ-045 Deliver 9 bytes with no rx_rd -> rx_ovf=1 after 9th, rx_count=8; ovf_clr -> rx_ovf=0.
REQ-046 Full RX FIFO with simultaneous rx_rd and new byte 8'hC3 -> rx_count stays 8, C3 is the last byte read out.
REQ-047 Assert rst=0 during T_WAIT with 3 bytes queued -> tx_count=0, send=0 immediately, no send pulse after release.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// Purpose: host-side byte FIFOs (TX and RX) bridging a host bus to a simple UART transmitter/receiver handshake.
// Latency: a TX byte reaches out_byte 2 cycles after T_IDLE sees it queued; an RX byte is readable the cycle after data_rdy.
// Backpressure: tx_wr is ignored while TX is full; a received byte arriving on a full RX FIFO is dropped and sets rx_ovf.
//
// Ports:
//   clk, rst (async active-low)
//   host TX : tx_wr, tx_data -> tx_full, tx_count
//   host RX : rx_rd -> rx_data (show-ahead), rx_empty, rx_count, rx_ovf; ovf_clr
//   UART TX : cts -> send, out_byte
//   UART RX : data_rdy, in_byte -> clear
module uart_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_wr,
    input  logic [7:0]    tx_data,
    output logic          tx_full,
    output logic [AW:0]   tx_count,
    input  logic          rx_rd,
    output logic [7:0]    rx_data,
    output logic          rx_empty,
    output logic [AW:0]   rx_count,
    output logic          rx_ovf,
    input  logic          ovf_clr,
    input  logic          cts,
    output logic          send,
    output logic [7:0]    out_byte,
    input  logic          data_rdy,
    input  logic [7:0]    in_byte,
    output logic          clear
);

    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_START, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [AW:0]   r_tx_count, r_rx_count;
    logic [7:0]    r_out_byte;
    logic          r_rx_ovf;
    logic          r_tx_hold;
    tx_state_t     r_tx_state, w_tx_next;
    rx_state_t     r_rx_state, w_rx_next;

    logic w_tx_full, w_tx_push, w_tx_pop;
    logic w_rx_take, w_rx_push, w_rx_pop, w_rx_drop;
    logic w_send, w_clear;

    // A pop in the same cycle frees a slot, so a push on a full FIFO is accepted then.
    assign w_tx_full = (r_tx_count == L_FULL);
    assign w_tx_pop  = (r_tx_state == T_LOAD);
    assign w_tx_push = tx_wr && (!w_tx_full || w_tx_pop);

    // Each data_rdy assertion is sampled only in R_IDLE, giving exactly one push or drop.
    assign w_rx_take = (r_rx_state == R_IDLE) && data_rdy;
    assign w_rx_pop  = rx_rd && (r_rx_count != '0);
    assign w_rx_push = w_rx_take && ((r_rx_count != L_FULL) || w_rx_pop);
    assign w_rx_drop = w_rx_take && !w_rx_push;

    assign tx_full  = w_tx_full;
    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;
    assign rx_empty = (r_rx_count == '0);
    assign rx_data  = r_rx_mem[r_rx_rptr];
    assign rx_ovf   = r_rx_ovf;
    assign out_byte = r_out_byte;
    assign send     = w_send;
    assign clear    = w_clear;

    // Storage is not reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= in_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_rx_ovf   <= 1'b0;
            r_out_byte <= 8'h00;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop) begin
                r_tx_rptr  <= r_tx_rptr + 1'b1;
                r_out_byte <= r_tx_mem[r_tx_rptr];
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: ;
            endcase

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: ;
            endcase

            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (w_rx_drop)    r_rx_ovf <= 1'b1;
            else if (ovf_clr) r_rx_ovf <= 1'b0;
        end
    end

    // State registers; r_tx_hold is high from the second T_WAIT cycle on, so the
    // transmitter gets one cycle after send to drop cts before it is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= T_IDLE;
            r_rx_state <= R_IDLE;
            r_tx_hold  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
            r_tx_hold  <= (r_tx_state == T_WAIT);
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_send    = 1'b0;
        case (r_tx_state)
            T_IDLE:  if ((r_tx_count != '0) && cts) w_tx_next = T_LOAD;
            T_LOAD:  w_tx_next = T_START;
            T_START: begin
                w_send    = 1'b1;
                w_tx_next = T_WAIT;
            end
            T_WAIT:  if (r_tx_hold && cts) w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_clear   = 1'b0;
        case (r_rx_state)
            R_IDLE:  if (data_rdy) w_rx_next = R_ACK;
            R_ACK: begin
                w_clear   = 1'b1;
                w_rx_next = R_WAIT;
            end
            R_WAIT:  if (!data_rdy) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Purpose: self-checking bench for uart_fifo_ctrl using byte scoreboards for both directions.
// Latency: checks sample on the falling edge, inputs are driven on the falling edge.
// Backpressure: full/empty boundaries and overflow behaviour are exercised explicitly.
module tb_uart_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          tx_full;
    logic [AW:0]   tx_count;
    logic          rx_rd;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic [AW:0]   rx_count;
    logic          rx_ovf;
    logic          ovf_clr;
    logic          cts;
    logic          send;
    logic [7:0]    out_byte;
    logic          data_rdy;
    logic [7:0]    in_byte;
    logic          clear;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_ovf(rx_ovf), .ovf_clr(ovf_clr),
        .cts(cts), .send(send), .out_byte(out_byte),
        .data_rdy(data_rdy), .in_byte(in_byte), .clear(clear)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_send = 0;
    int n_clear = 0;
    int rx_cnt_m = 0;
    bit ovf_m = 1'b0;
    logic send_d = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // TX scoreboard: every send pulse must match the oldest accepted byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (send) begin
            n_send++;
            chk("send_one_cycle", send_d, 1'b0);
            chk("send_expected", (tx_q.size() != 0), 1'b1);
            if (tx_q.size() != 0) begin
                e = tx_q.pop_front();
                chk("out_byte", out_byte, e);
            end
        end
        if (clear) n_clear++;
        send_d = send;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tx_push(input logic [7:0] b, input bit acc);
        tx_wr = 1'b1;
        tx_data = b;
        if (acc) tx_q.push_back(b);
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (send) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, got, 1'b1);
    endtask

    task automatic wait_clear(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (clear) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, got, 1'b1);
    endtask

    task automatic cts_bounce();
        @(negedge clk);
        cts = 1'b0;
        repeat (20) @(negedge clk);
        cts = 1'b1;
    endtask

    task automatic rx_read();
        logic [7:0] e;
        e = rx_q.pop_front();
        chk("rx_data", rx_data, e);
        rx_rd = 1'b1;
        rx_cnt_m--;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    // Receiver delivers one byte; optionally pops the RX head and/or pulses ovf_clr in the same cycle.
    task automatic rx_deliver(input logic [7:0] b, input bit clr, input bit rd_too);
        logic [7:0] e;
        data_rdy = 1'b1;
        in_byte  = b;
        ovf_clr  = clr;
        if (rd_too) begin
            e = rx_q.pop_front();
            chk("rx_head_on_rd", rx_data, e);
            rx_cnt_m--;
            rx_rd = 1'b1;
        end
        if (rx_cnt_m < DEPTH) begin
            rx_q.push_back(b);
            rx_cnt_m++;
        end else begin
            ovf_m = 1'b1;
        end
        if (clr && rx_cnt_m < DEPTH) ovf_m = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        rx_rd   = 1'b0;
        wait_clear("rx_clear_seen");
        @(negedge clk);
        data_rdy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ovf_clear_pulse();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        ovf_m = 1'b0;
    endtask

    int snap;

    initial begin
        rst = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; ovf_clr = 1'b0;
        cts = 1'b0; data_rdy = 1'b0; in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_ovf", rx_ovf, 0);
        chk("rst_send", send, 0);
        chk("rst_clear", clear, 0);
        chk("rst_out_byte", out_byte, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        // Two bytes with the transmitter dropping cts after each send.
        cts = 1'b1;
        tx_push(8'h41, 1'b1);
        tx_push(8'h42, 1'b1);
        chk("tx_count_two", tx_count, 2);
        wait_send("tx_send1_seen");
        cts_bounce();
        wait_send("tx_send2_seen");
        cts_bounce();
        repeat (5) @(negedge clk);
        chk("tx_count_drained", tx_count, 0);
        chk("tx_sends_two", n_send, 2);

        // Fill TX with cts low; the ninth push is ignored.
        cts = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tx_push(8'h10 + 8'(i), i < 8);
            if (i == 6) chk("tx_full_at7", tx_full, 0);
            if (i == 7) begin
                chk("tx_full_at8", tx_full, 1);
                chk("tx_count_at8", tx_count, 8);
            end
        end
        chk("tx_count_after9", tx_count, 8);
        chk("tx_full_after9", tx_full, 1);
        cts = 1'b1;
        repeat (60) @(negedge clk);
        chk("tx_count_empty2", tx_count, 0);
        chk("tx_sends_ten", n_send, 10);
        chk("tx_q_consumed", tx_q.size(), 0);

        // Single received byte.
        rx_deliver(8'h5A, 1'b0, 1'b0);
        chk("rx_one_clear", n_clear, 1);
        chk("rx_count_one", rx_count, 1);
        chk("rx_not_empty", rx_empty, 0);
        rx_read();
        chk("rx_empty_after_rd", rx_empty, 1);

        // Read on an empty FIFO changes nothing.
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        chk("rx_rd_empty_count", rx_count, 0);
        chk("rx_rd_empty_flag", rx_empty, 1);

        // Overflow: nine bytes with no reads.
        for (int i = 0; i < 9; i++) begin
            rx_deliver(8'h60 + 8'(i), 1'b0, 1'b0);
            if (i == 7) begin
                chk("rx_ovf_at8", rx_ovf, ovf_m);
                chk("rx_count_at8", rx_count, rx_cnt_m);
            end
        end
        chk("rx_ovf_after9", rx_ovf, ovf_m);
        chk("rx_count_after9", rx_count, 8);
        ovf_clear_pulse();
        chk("rx_ovf_cleared", rx_ovf, ovf_m);
        // Drop coinciding with ovf_clr leaves the flag set.
        rx_deliver(8'h99, 1'b1, 1'b0);
        chk("rx_ovf_set_wins", rx_ovf, 1);
        ovf_clear_pulse();
        chk("rx_ovf_cleared2", rx_ovf, 0);

        // Full FIFO, simultaneous read and new byte.
        rx_deliver(8'hC3, 1'b0, 1'b1);
        chk("rx_count_stays8", rx_count, 8);
        chk("rx_no_ovf_on_rdpush", rx_ovf, ovf_m);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("rx_last_c3", rx_data, 8'hC3);
            rx_read();
        end
        chk("rx_empty_final", rx_empty, 1);
        chk("rx_clear_total", n_clear, 12);

        // Reset while in T_WAIT with three bytes still queued.
        cts = 1'b1;
        snap = n_send;
        for (int i = 0; i < 4; i++) tx_push(8'hB0 + 8'(i), 1'b1);
        cts = 1'b0;
        repeat (3) @(negedge clk);
        chk("tx_sent_one_before_rst", n_send, snap + 1);
        chk("tx_count_three", tx_count, 3);
        rst = 1'b0;
        #1;
        chk("rst_async_tx_count", tx_count, 0);
        chk("rst_async_send", send, 0);
        chk("rst_async_out_byte", out_byte, 8'h00);
        tx_q.delete();
        snap = n_send;
        @(negedge clk);
        rst = 1'b1;
        cts = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_send_after_rst", n_send, snap);
        chk("tx_count_after_rst", tx_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
